// File: rtl/fifo_16x16x20b_pkg.sv
// Shared constants for the systolic-array delay FIFOs: lane count, lane widths,
// delay depths, bench clock period and the lane packing helper.
package fifo_16x16x20b_pkg;

  localparam int NUM_LANES    = 16;
  localparam int WIDTH_WIDE   = 20;
  localparam int WIDTH_NARROW = 8;
  localparam int DEPTH_SHORT  = 16;
  localparam int DEPTH_LONG   = 256;

  localparam int CLK_PERIOD_NS = 10;
  localparam int CLK_HALF_NS   = CLK_PERIOD_NS / 2;

  // Lane 0 sits in the MSBs of a packed bus, so lane L starts this many bits up.
  function automatic int laneLsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/fifo_16x16x20b_lane.sv
// One lane of the delay FIFO: a DEPTH-stage register chain that advances on en_i
// and presents the oldest stage on dout_o.
module fifo_lane #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // Output comes straight from the last register, so din never reaches dout combinationally.
  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fifo_256x16x8b.sv
// 256-deep, 16-lane, 8-bit variant of the delay FIFO with the same port list.
// Note: reset_n is an active-high asynchronous reset despite its name.
module fifo_256x16x8b
  import fifo_16x16x20b_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic [NUM_LANES*WIDTH_NARROW-1:0] din,
  output logic [NUM_LANES*WIDTH_NARROW-1:0] dout
);

  fifo_16x16x20b #(
    .DEPTH (DEPTH_LONG),
    .LANES (NUM_LANES),
    .WIDTH (WIDTH_NARROW)
  ) uFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (din),
    .dout    (dout)
  );

endmodule

// File: rtl/fifo_16x16x20b.sv
// LANES parallel DEPTH-stage delay lines sharing one shift enable.
// Note: reset_n is an active-high asynchronous reset despite its name.
module fifo_16x16x20b
  import fifo_16x16x20b_pkg::*;
#(
  parameter int DEPTH = DEPTH_SHORT,
  parameter int LANES = NUM_LANES,
  parameter int WIDTH = WIDTH_WIDE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : gLane
    fifo_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) uLane (
      .clk_i  (clk),
      .rst_i  (reset_n),
      .en_i   (en),
      .din_i  (din[laneLsb(i, LANES, WIDTH) +: WIDTH]),
      .dout_o (dout[laneLsb(i, LANES, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_fifo_16x16x20b.sv
// Bench for the 16-deep 20-bit FIFO and its 256-deep 8-bit wrapper, using a
// queue scoreboard per DUT plus hand-computed checkpoints.
module tb_fifo_16x16x20b;
  import fifo_16x16x20b_pkg::*;

  localparam int W20 = NUM_LANES * WIDTH_WIDE;
  localparam int W8  = NUM_LANES * WIDTH_NARROW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           en20 = 1'b0;
  logic           en8 = 1'b0;
  logic [W20-1:0] din20 = '0;
  logic [W8-1:0]  din8 = '0;
  logic [W20-1:0] dout20;
  logic [W8-1:0]  dout8;

  fifo_16x16x20b uDut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en20),
    .din     (din20),
    .dout    (dout20)
  );

  fifo_256x16x8b uDut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en8),
    .din     (din8),
    .dout    (dout8)
  );

  always #(CLK_HALF_NS) clk = ~clk;

  typedef struct {
    logic        en;
    int          dinJ;
    bit          hasExp;
    logic [19:0] exp0;
    logic [19:0] exp15;
  } vecT;

  vecT            vecs [76];
  logic [W20-1:0] q20 [$];
  logic [W8-1:0]  q8 [$];
  logic [W20-1:0] exp20;
  logic [W8-1:0]  exp8;
  int             compared = 0;
  int             mismatched = 0;

  function automatic logic [W20-1:0] fillBus(input int j);
    logic [W20-1:0] b;
    logic [19:0]    v;
    b = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      v = 20'(-(i + 1) * (j + 1));
      b[(NUM_LANES-1-i)*20 +: 20] = v;
    end
    return b;
  endfunction

  function automatic logic [19:0] lane20(input logic [W20-1:0] b, input int i);
    return b[(NUM_LANES-1-i)*20 +: 20];
  endfunction

  task automatic checkOutput(input string name, input logic [W20-1:0] act, input logic [W20-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic resetModels();
    q20.delete();
    q8.delete();
    for (int i = 0; i < DEPTH_SHORT - 1; i++) q20.push_back('0);
    for (int i = 0; i < DEPTH_LONG - 1; i++) q8.push_back('0);
    exp20 = '0;
    exp8  = '0;
  endtask

  // Inputs change just after a falling edge; outputs are compared 1 ns after the rising edge.
  task automatic applyStimulus(input string name, input logic e20, input logic [W20-1:0] d20,
                               input logic e8, input logic [W8-1:0] d8);
    en20  = e20;
    din20 = d20;
    en8   = e8;
    din8  = d8;
    @(posedge clk);
    if (reset_n) begin
      resetModels();
    end else begin
      if (e20) begin
        q20.push_back(d20);
        exp20 = q20.pop_front();
      end
      if (e8) begin
        q8.push_back(d8);
        exp8 = q8.pop_front();
      end
    end
    #1;
    checkOutput({name, "_dout20"}, dout20, exp20);
    checkOutput({name, "_dout8"}, W20'(dout8), W20'(exp8));
    @(negedge clk);
  endtask

  initial begin
    logic [W8-1:0] tokenBus;
    logic [W8-1:0] rnd8;
    logic [W20-1:0] rnd20;
    int n8;
    logic e;

    resetModels();
    #2 reset_n = 1'b1;
    #1;
    checkOutput("reset_async_dout20", dout20, '0);
    checkOutput("reset_async_dout8", W20'(dout8), '0);
    @(negedge clk);
    applyStimulus("reset_override", 1'b1, fillBus(7), 1'b1, 128'h1);
    reset_n = 1'b0;
    for (int c = 0; c < 5; c++) applyStimulus("post_reset_zero", 1'b1, '0, 1'b0, '0);

    for (int idx = 0; idx < 76; idx++) begin
      vecs[idx].hasExp = 1'b0;
      vecs[idx].exp0   = '0;
      vecs[idx].exp15  = '0;
      if (idx < 30) begin
        vecs[idx].en = 1'b1; vecs[idx].dinJ = idx;
      end else if (idx < 60) begin
        vecs[idx].en = 1'b0; vecs[idx].dinJ = 500 + idx;
      end else begin
        vecs[idx].en = 1'b1; vecs[idx].dinJ = idx - 30;
      end
    end
    vecs[14] = '{1'b1, 14, 1'b1, 20'h00000, 20'h00000};
    vecs[15] = '{1'b1, 15, 1'b1, 20'hFFFFF, 20'hFFFF0};
    vecs[16] = '{1'b1, 16, 1'b1, 20'hFFFFE, 20'hFFFE0};
    vecs[29] = '{1'b1, 29, 1'b1, 20'hFFFF1, 20'hFFF10};
    vecs[59] = '{1'b0, 559, 1'b1, 20'hFFFF1, 20'hFFF10};
    vecs[60] = '{1'b1, 30, 1'b1, 20'hFFFF0, 20'hFFF00};
    vecs[61] = '{1'b1, 31, 1'b1, 20'hFFFEF, 20'hFFEF0};

    for (int idx = 0; idx < 76; idx++) begin
      applyStimulus("fill_hold_resume", vecs[idx].en, fillBus(vecs[idx].dinJ), 1'b0, '0);
      if (vecs[idx].hasExp) begin
        checkOutput($sformatf("vec%0d_lane0", idx), W20'(lane20(dout20, 0)), W20'(vecs[idx].exp0));
        checkOutput($sformatf("vec%0d_lane15", idx), W20'(lane20(dout20, 15)), W20'(vecs[idx].exp15));
      end
    end

    for (int c = 0; c < 40; c++) begin
      rnd20 = '0;
      for (int k = 0; k < 10; k++) rnd20[k*32 +: 32] = $urandom;
      rnd8 = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      applyStimulus("random_en", e, rnd20, ~e, rnd8);
    end

    for (int c = 0; c < 10; c++) applyStimulus("pre_reset_stream", 1'b1, fillBus(200 + c), 1'b1, 128'hFF << c);
    #2 reset_n = 1'b1;
    #1;
    resetModels();
    checkOutput("midstream_reset_dout20", dout20, '0);
    checkOutput("midstream_reset_dout8", W20'(dout8), '0);
    applyStimulus("reset_held", 1'b1, fillBus(300), 1'b1, 128'h5A);
    applyStimulus("reset_held", 1'b1, fillBus(301), 1'b1, 128'hA5);
    reset_n = 1'b0;
    for (int c = 0; c < 20; c++) applyStimulus("no_leak", 1'b1, '0, 1'b1, '0);

    tokenBus = '0;
    tokenBus[(NUM_LANES-1-3)*8 +: 8] = 8'hA5;
    n8 = 0;
    for (int c = 0; c < 400 && n8 < 260; c++) begin
      e = (c % 7 == 3) ? 1'b0 : 1'b1;
      applyStimulus("token8", 1'b0, '0, e, (e && n8 == 0) ? tokenBus : '0);
      if (e) begin
        n8++;
        if (n8 == 255) checkOutput("token8_edge255", W20'(dout8), '0);
        if (n8 == 256) checkOutput("token8_edge256", W20'(dout8), W20'(tokenBus));
        if (n8 == 257) checkOutput("token8_edge257", W20'(dout8), '0);
      end
    end
    if (n8 < 260) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL token8_budget: enabled edges %0d want 260", n8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
